// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: system-clocked PS/2 receiver with prefix decode, event FIFO and direction register
module ps2_keyboard_rx #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_AW     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_release,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [4:0] direcao,
  output logic       frame_err,
  output logic       overflow
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [1:0] clk_sync, dat_sync;
  logic filt, filt_q;
  logic [FW-1:0] fcnt;
  logic strobe, bit_in, good;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic par;
  logic [TW-1:0] tcnt;
  logic byte_valid, ext_pend, rel_pend;
  logic [9:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0] count;
  logic is_pre, push_req, full, pop, push;
  logic [4:0] dir_map;
  assign strobe = filt_q & ~filt;
  assign bit_in = dat_sync[1];
  assign good = bit_in & ^{shreg, par};
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt <= 1'b1;
      filt_q <= 1'b1;
      fcnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      filt_q <= filt;
      if (clk_sync[1] == filt) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bcnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      tcnt <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      tcnt <= (state == IDLE || strobe) ? '0 : tcnt + 1'b1;
      if (state != IDLE && tcnt == TW'(TIMEOUT_CYC)) begin
        state <= IDLE;
        frame_err <= 1'b1;
        tcnt <= '0;
      end else if (strobe) begin
        case (state)
          IDLE: if (!bit_in) begin
            state <= DATA;
            bcnt <= '0;
          end
          DATA: begin
            shreg <= {bit_in, shreg[7:1]};
            bcnt <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par <= bit_in;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            byte_valid <= good;
            frame_err <= ~good;
          end
        endcase
      end
    end
  end
  assign is_pre = shreg == 8'hE0 || shreg == 8'hF0;
  assign push_req = byte_valid && !is_pre;
  assign full = count[FIFO_AW];
  assign evt_valid = count != '0;
  assign pop = evt_valid && evt_ready;
  assign push = push_req && (!full || pop);
  assign {evt_ext, evt_release, evt_code} = evt_valid ? mem[rp] : 10'd0;
  always_comb
    dir_map = (shreg == 8'h75 || shreg == 8'h1D) ? 5'b00010 :
              (shreg == 8'h6B || shreg == 8'h1C) ? 5'b00100 :
              (shreg == 8'h72 || shreg == 8'h1B) ? 5'b01000 :
              (shreg == 8'h74 || shreg == 8'h23) ? 5'b10000 :
              (shreg == 8'h29)                   ? 5'b00111 : direcao;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {ext_pend, rel_pend, shreg};
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_pend <= 1'b0;
      rel_pend <= 1'b0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      direcao <= '0;
      overflow <= 1'b0;
    end else begin
      if (frame_err) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (byte_valid) begin
        ext_pend <= (shreg == 8'hE0) | (is_pre & ext_pend);
        rel_pend <= (shreg == 8'hF0) | (is_pre & rel_pend);
      end
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
      if (push_req && full && !pop) overflow <= 1'b1;
      if (push_req && rel_pend) direcao <= dir_map;
    end
  end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: randomized PS/2 frame bench against a queue-based event model
module tb_ps2_keyboard_rx;
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic rdy_man = 1'b0, rnd_en = 1'b0, rnd_bit = 1'b0, evt_ready;
  logic [7:0] evt_code;
  logic evt_ext, evt_release, evt_valid, frame_err, overflow;
  logic [4:0] direcao;
  int cyc, npass, ntot, nerr, err_cyc, npop, lat, dcyc, nbad, e0;
  logic [9:0] q[$];
  logic m_ext, m_rel, m_ovf;
  logic [4:0] m_dir;
  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h75, 8'h1D, 8'h6B, 8'h1C, 8'h72, 8'h1B, 8'h74, 8'h23, 8'h29, 8'hE1};
  assign evt_ready = rdy_man | (rnd_en & rnd_bit);
  ps2_keyboard_rx #(.TIMEOUT_CYC(400)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_release(evt_release),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .direcao(direcao),
    .frame_err(frame_err), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk) if (!reset) begin
    if (frame_err) begin
      nerr++;
      err_cyc = cyc;
    end
    if (evt_valid && evt_ready) begin
      npop++;
      chk("pop_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) chk("pop_evt", {evt_ext, evt_release, evt_code}, q.pop_front());
    end
  end
  function automatic logic [4:0] dirmap(input logic [7:0] c, input logic [4:0] d);
    case (c)
      8'h75, 8'h1D: return 5'b00010;
      8'h6B, 8'h1C: return 5'b00100;
      8'h72, 8'h1B: return 5'b01000;
      8'h74, 8'h23: return 5'b10000;
      8'h29:        return 5'b00111;
      default:      return d;
    endcase
  endfunction
  task automatic model_byte(input logic [7:0] b, input logic ok);
    if (!ok) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else begin
      if (q.size() < 8) q.push_back({m_ext, m_rel, b});
      else m_ovf = 1'b1;
      if (m_rel) m_dir = dirmap(b, m_dir);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask
  task automatic model_reset();
    q.delete();
    {m_ext, m_rel, m_ovf, m_dir} = '0;
  endtask
  // Bits go out LSB first; the model is updated at the last falling edge so it leads the DUT
  task automatic send_bits(input logic [10:0] bits, input int n, input logic glitch,
                           input logic mdl, input logic ok, output int l, output int dc);
    logic was;
    l = 0;
    dc = 0;
    for (int i = 0; i < n; i++) begin
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (k == 10) ps2_data = bits[i];
        if (glitch && k == 4) ps2_clk = 1'b0;
        if (glitch && k == 6) ps2_clk = 1'b1;
      end
      ps2_clk = 1'b0;
      dc = cyc;
      was = evt_valid;
      if (mdl && i == n - 1) model_byte(bits[8:1], ok);
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (!was && evt_valid && l == 0) l = k;
        if (glitch && k == 8) ps2_clk = 1'b1;
        if (glitch && k == 10) ps2_clk = 1'b0;
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic badpar, input logic glitch, output int l);
    int dc;
    send_bits({1'b1, ~^b ^ badpar, b, 1'b0}, 11, glitch, 1'b1, ~badpar, l, dc);
    repeat (20) @(posedge clk);
    #1;
  endtask
  task automatic pop1();
    @(posedge clk); #1 rdy_man = 1'b1;
    @(posedge clk); #1 rdy_man = 1'b0;
  endtask
  task automatic head(input string tag, input logic [9:0] exp);
    chk({tag, "_valid"}, evt_valid, 1);
    chk({tag, "_head"}, {evt_ext, evt_release, evt_code}, exp);
  endtask
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_outputs", {evt_code, evt_ext, evt_release, evt_valid, direcao, frame_err, overflow}, 0);
    send_frame(8'hF0, 0, 0, lat);
    send_frame(8'h1D, 0, 0, lat);
    chk("latency", lat, 8);
    head("f0_1d", {2'b01, 8'h1D});
    chk("f0_1d_dir", direcao, 5'b00010);
    chk("f0_1d_noerr", nerr, 0);
    pop1();
    send_frame(8'hE0, 0, 0, lat);
    send_frame(8'hF0, 0, 0, lat);
    send_frame(8'h6B, 0, 0, lat);
    head("e0f0_6b", {2'b11, 8'h6B});
    chk("e0f0_6b_dir", direcao, 5'b00100);
    pop1();
    chk("after_pop_valid", evt_valid, 0);
    e0 = nerr;
    send_frame(8'h29, 1, 0, lat);
    chk("badpar_err", nerr - e0, 1);
    chk("badpar_noevt", evt_valid, 0);
    send_frame(8'hF0, 0, 0, lat);
    send_frame(8'h29, 0, 0, lat);
    head("f0_29", {2'b01, 8'h29});
    chk("f0_29_dir", direcao, 5'b00111);
    pop1();
    e0 = nerr;
    send_frame(8'hF0, 0, 0, lat);
    send_bits(11'h0aa, 5, 0, 0, 0, lat, dcyc);
    repeat (500) @(posedge clk);
    #1;
    model_byte(8'h00, 0);
    chk("timeout_err", nerr - e0, 1);
    chk("timeout_when", 32'(err_cyc - dcyc >= 400 && err_cyc - dcyc <= 416), 1);
    send_frame(8'h1C, 0, 0, lat);
    head("after_to_1c", {2'b00, 8'h1C});
    chk("after_to_dir", direcao, 5'b00111);
    pop1();
    for (int i = 0; i < 9; i++) send_frame(8'h1C, 0, 0, lat);
    chk("ovf_flag", overflow, 1);
    chk("ovf_model", overflow, m_ovf);
    npop = 0;
    rdy_man = 1'b1;
    repeat (20) @(posedge clk);
    #1 rdy_man = 1'b0;
    chk("drain_pops", npop, 8);
    chk("drain_empty", evt_valid, 0);
    e0 = nerr;
    send_frame(8'hF0, 0, 1, lat);
    send_frame(8'h75, 0, 1, lat);
    head("glitch_75", {2'b01, 8'h75});
    chk("glitch_dir", direcao, 5'b00010);
    chk("glitch_noerr", nerr - e0, 0);
    pop1();
    send_frame(8'hF0, 0, 0, lat);
    send_bits(11'h0aa, 4, 0, 0, 0, lat, dcyc);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_outputs", {evt_code, evt_ext, evt_release, evt_valid, direcao, frame_err, overflow}, 0);
    reset = 1'b0;
    model_reset();
    send_frame(8'h23, 0, 0, lat);
    head("post_rst_23", {2'b00, 8'h23});
    chk("post_rst_dir", direcao, 5'b00000);
    pop1();
    e0 = nerr;
    nbad = 0;
    rnd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int r;
      logic bp;
      logic [7:0] b;
      r = $urandom_range(0, 12);
      b = (r == 12) ? 8'($urandom) : pool[r];
      bp = ($urandom_range(0, 9) == 0);
      nbad += int'(bp);
      send_frame(b, bp, 1'($urandom_range(0, 1)), lat);
    end
    rnd_en = 1'b0;
    rdy_man = 1'b1;
    repeat (30) @(posedge clk);
    #1 rdy_man = 1'b0;
    chk("rnd_model_empty", q.size(), 0);
    chk("rnd_dut_empty", evt_valid, 0);
    chk("rnd_dir", direcao, m_dir);
    chk("rnd_ovf", overflow, m_ovf);
    chk("rnd_errs", nerr - e0, nbad);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
